// File: rtl/memory_stage.sv
// MEM stage of the five-stage MIPS pipeline: performs LW/SW data-bus accesses through a
// request/response handshake, passes other instructions through with one cycle of latency,
// and exposes a forwarding tap on the Writeback record.
//
// Record layouts, MSB first:
//   in_m  [120:0] = {dst_e[4:0], dst_m[4:0], val_a[31:0], val_e[31:0], stat[2:0],
//                    opcode[5:0], funct[5:0], pc[31:0]}
//   out_w [108:0] = {dst_e[4:0], dst_m[4:0], val_e[31:0], val_m[31:0], stat[2:0], pc[31:0]}
module memory_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [120:0] in_m,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [108:0] out_w,
    output logic         dreq_valid,
    output logic [31:0]  dreq_addr,
    output logic [3:0]   dreq_strobe,
    output logic [31:0]  dreq_data,
    input  logic         dresp_addr_ok,
    input  logic         dresp_data_ok,
    input  logic [31:0]  dresp_data,
    output logic         fwd_valid,
    output logic [4:0]   fwd_dst,
    output logic [31:0]  fwd_val
);

    typedef struct packed {
        logic [4:0]  dst_e;
        logic [4:0]  dst_m;
        logic [31:0] val_a;
        logic [31:0] val_e;
        logic [2:0]  stat;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [31:0] pc;
    } plr_m_t;

    typedef struct packed {
        logic [4:0]  dst_e;
        logic [4:0]  dst_m;
        logic [31:0] val_e;
        logic [31:0] val_m;
        logic [2:0]  stat;
        logic [31:0] pc;
    } plr_w_t;

    typedef enum logic [1:0] {StIdle = 2'd0, StAddr = 2'd1, StData = 2'd2} state_e;

    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;
    localparam logic [2:0] StatAdr = 3'd3;

    plr_m_t in_rec;
    plr_m_t cur_q;
    plr_w_t out_q, out_d;
    state_e state_q, state_d;
    logic   out_valid_q, out_valid_d;
    logic   out_lw_q, out_lw_d;
    logic   in_is_mem, in_aligned, accept, start_mem, complete, cur_is_lw;

    assign in_rec     = in_m;
    assign in_is_mem  = (in_rec.opcode == OpLw) || (in_rec.opcode == OpSw);
    assign in_aligned = (in_rec.val_e[1:0] == 2'b00);
    assign accept     = in_valid && in_ready;
    assign start_mem  = accept && in_is_mem && in_aligned;
    assign cur_is_lw  = (cur_q.opcode == OpLw);
    assign complete   = ((state_q == StAddr) && dresp_addr_ok && dresp_data_ok) ||
                        ((state_q == StData) && dresp_data_ok);

    // funct never influences the MEM stage; sink it to keep lint quiet
    logic unused_funct;
    assign unused_funct = ^{in_rec.funct, cur_q.funct};

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next-state logic; bus responses in IDLE are ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_mem) state_d = StAddr;
            StAddr: begin
                if (dresp_addr_ok && dresp_data_ok) state_d = StIdle;
                else if (dresp_addr_ok)             state_d = StData;
            end
            StData: if (dresp_data_ok) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: handshake and bus request, held stable from cur_q while in ADDR
    always_comb begin
        in_ready    = (state_q == StIdle) && (!out_valid_q || out_ready);
        dreq_valid  = 1'b0;
        dreq_addr   = '0;
        dreq_strobe = '0;
        dreq_data   = '0;
        if (state_q == StAddr) begin
            dreq_valid = 1'b1;
            dreq_addr  = cur_q.val_e;
            if (!cur_is_lw) begin
                dreq_strobe = 4'hF;
                dreq_data   = cur_q.val_a;
            end
        end
    end

    // Captured memory instruction, held for the whole bus transaction
    always_ff @(posedge clk) begin
        if (reset)          cur_q <= '0;
        else if (start_mem) cur_q <= in_rec;
    end

    // Writeback record next value: drain, then overlay a fresh load if one happens
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_lw_d    = out_lw_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept && !start_mem) begin
            out_d.dst_e = in_rec.dst_e;
            out_d.dst_m = in_rec.dst_m;
            out_d.val_e = in_rec.val_e;
            out_d.val_m = '0;
            out_d.stat  = in_is_mem ? StatAdr : in_rec.stat;
            out_d.pc    = in_rec.pc;
            out_lw_d    = (in_rec.opcode == OpLw);
            out_valid_d = 1'b1;
        end else if (complete) begin
            out_d.dst_e = cur_q.dst_e;
            out_d.dst_m = cur_q.dst_m;
            out_d.val_e = cur_q.val_e;
            out_d.val_m = cur_is_lw ? dresp_data : '0;
            out_d.stat  = cur_q.stat;
            out_d.pc    = cur_q.pc;
            out_lw_d    = cur_is_lw;
            out_valid_d = 1'b1;
        end
    end

    // Writeback record register
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_lw_q    <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_lw_q    <= out_lw_d;
        end
    end

    // Output record and forwarding tap
    always_comb begin
        out_w     = out_q;
        out_valid = out_valid_q;
        fwd_valid = out_valid_q;
        fwd_dst   = out_lw_q ? out_q.dst_m : out_q.dst_e;
        fwd_val   = out_lw_q ? out_q.val_m : out_q.val_e;
    end

endmodule
